// File: rtl/fft_deser_pkg.sv
// Shared types and helpers for the FFT input deserializer: FSM state encoding
// and the frame-index width function used by the top and the index mapper.
package fft_deser_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  // Width of a frame index; a 1-sample frame would still need one bit.
  function automatic int idx_width(input int n_samples);
    return (n_samples < 2) ? 1 : $clog2(n_samples);
  endfunction

endpackage

// File: rtl/fft_index_mapper.sv
// Combinational sample-index to buffer-slot map. FFT_DESER_BITREV_EN selects
// bit-reversed order (for a decimation-in-time first stage); otherwise natural order.
module fft_index_mapper
  import fft_deser_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  localparam int IDX_W    = idx_width(N_SAMPLES)
) (
  input  logic [IDX_W-1:0] index,
  output logic [IDX_W-1:0] mapped
);

`ifdef FFT_DESER_BITREV_EN
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
    mapped = '0;
    for (int b = 0; b < IDX_W; b++) begin
      mapped[b] = index[IDX_W-1-b];
    end
  end
`else
  assign mapped = index;
`endif

endmodule

// File: rtl/fft_input_deserializer.sv
// Collects N_SAMPLES serial real samples into one parallel complex frame for the
// first FFT stage. Slot order is set by FFT_DESER_BITREV_EN (see fft_index_mapper).
module fft_input_deserializer
  import fft_deser_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [BIT_WIDTH-1:0]                recv_msg,
  input  logic                                recv_val,
  output logic                                recv_rdy,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_msg_real,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_msg_imag,
  output logic                                send_val,
  input  logic                                send_rdy
);

  localparam int IDX_W = idx_width(N_SAMPLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

  state_t                              state;
  logic [IDX_W-1:0]                    count;
  logic [IDX_W-1:0]                    slot;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] buffer;
  logic                                accept;

  fft_index_mapper #(
    .N_SAMPLES (N_SAMPLES)
  ) u_index_mapper (
    .index  (count),
    .mapped (slot)
  );

  // recv_rdy is a flop that is high exactly in FILL, so accept only occurs in FILL.
  assign accept = recv_val && recv_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FILL;
      count    <= '0;
      recv_rdy <= 1'b1;
      send_val <= 1'b0;
      // NOTE: the frame buffer is reset because it drives send_msg_real directly and must read zero in reset.
      buffer   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop here samples pre-edge values.
      case (state)
        FILL: begin
          if (accept) begin
            buffer[slot] <= recv_msg;
            count        <= count + 1'b1;
            if (count == LAST_IDX) begin
              state    <= FULL;
              recv_rdy <= 1'b0;
              send_val <= 1'b1;
            end
          end
        end
        FULL: begin
          if (send_rdy) begin
            state    <= FILL;
            recv_rdy <= 1'b1;
            send_val <= 1'b0;
          end
        end
        default: begin
          state    <= FILL;
          recv_rdy <= 1'b1;
          send_val <= 1'b0;
        end
      endcase
    end
  end

  assign send_msg_real = buffer;
  assign send_msg_imag = '0;

endmodule

// File: tb/tb_fft_input_deserializer.sv
// Directed self-checking bench for fft_input_deserializer (N_SAMPLES=8, BIT_WIDTH=32);
// expected slot order follows FFT_DESER_BITREV_EN.
module tb_fft_input_deserializer;

  localparam int BW = 32;
  localparam int NS = 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [BW-1:0]         recv_msg = '0;
  logic                  recv_val = 1'b0;
  logic                  recv_rdy;
  logic [NS-1:0][BW-1:0] send_msg_real;
  logic [NS-1:0][BW-1:0] send_msg_imag;
  logic                  send_val;
  logic                  send_rdy = 1'b0;

  int total  = 0;
  int passed = 0;
  int cycle  = 0;
  int frame_cycle = 0;
  int ord [NS];

  fft_input_deserializer #(
    .BIT_WIDTH (BW),
    .N_SAMPLES (NS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .recv_msg      (recv_msg),
    .recv_val      (recv_val),
    .recv_rdy      (recv_rdy),
    .send_msg_real (send_msg_real),
    .send_msg_imag (send_msg_imag),
    .send_val      (send_val),
    .send_rdy      (send_rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present one sample and hold it until the block has accepted it.
  task automatic drive_sample(input logic [BW-1:0] v);
    int waited = 0;
    recv_msg = v;
    recv_val = 1'b1;
    while (!recv_rdy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!recv_rdy) check("rdy_wait", 64'(recv_rdy), 64'd1);
    @(negedge clk);
  endtask

  task automatic send_frame(input bit bubbles, input int first);
    for (int k = 0; k < NS; k++) begin
      if (bubbles) begin
        recv_val = 1'b0;
        recv_msg = 32'hDEAD_0000;
        @(negedge clk);
      end
      drive_sample(32'(first + k) << 16);
    end
  endtask

  task automatic check_frame(input string tag, input int first);
    check({tag, ".send_val"}, 64'(send_val), 64'd1);
    check({tag, ".recv_rdy"}, 64'(recv_rdy), 64'd0);
    for (int i = 0; i < NS; i++) begin
      check($sformatf("%s.real[%0d]", tag, i), 64'(send_msg_real[i]),
            64'(32'(first + ord[i]) << 16));
      check($sformatf("%s.imag[%0d]", tag, i), 64'(send_msg_imag[i]), 64'd0);
    end
    frame_cycle = cycle;
  endtask

  initial begin
    int prev;
`ifdef FFT_DESER_BITREV_EN
    ord = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    ord = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

    // Outputs while reset is held low.
    repeat (2) @(negedge clk);
    check("rst.recv_rdy", 64'(recv_rdy), 64'd1);
    check("rst.send_val", 64'(send_val), 64'd0);
    check("rst.real0", 64'(send_msg_real[0]), 64'd0);
    check("rst.imag7", 64'(send_msg_imag[7]), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Reset mid-fill after 3 samples: partial frame must be discarded.
    send_rdy = 1'b1;
    for (int k = 0; k < 3; k++) drive_sample(32'(8'hA0 + k) << 16);
    recv_val = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("midrst.recv_rdy", 64'(recv_rdy), 64'd1);
    check("midrst.send_val", 64'(send_val), 64'd0);
    for (int i = 0; i < NS; i++)
      check($sformatf("midrst.real[%0d]", i), 64'(send_msg_real[i]), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Back-to-back frame 1..8, send_rdy high: one-cycle send_val.
    send_frame(1'b0, 1);
    recv_val = 1'b0;
    check_frame("b2b", 1);
    @(negedge clk);
    check("b2b.send_val_drop", 64'(send_val), 64'd0);
    check("b2b.recv_rdy_back", 64'(recv_rdy), 64'd1);

    // Bubbles: only valid cycles captured, same frame as back-to-back.
    send_frame(1'b1, 1);
    recv_val = 1'b0;
    check_frame("bubble", 1);
    @(negedge clk);

    // Backpressure: FULL holds for 10 cycles with recv_val high.
    send_rdy = 1'b0;
    send_frame(1'b0, 21);
    check_frame("bp", 21);
    recv_msg = 32'h00FF_0000;
    recv_val = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("bp.hold%0d.recv_rdy", c), 64'(recv_rdy), 64'd0);
      check($sformatf("bp.hold%0d.send_val", c), 64'(send_val), 64'd1);
      check($sformatf("bp.hold%0d.real0", c), 64'(send_msg_real[0]), 64'(32'(21 + ord[0]) << 16));
      check($sformatf("bp.hold%0d.real7", c), 64'(send_msg_real[7]), 64'(32'(21 + ord[7]) << 16));
    end
    send_rdy = 1'b1;
    recv_val = 1'b0;
    @(negedge clk);
    check("bp.release.send_val", 64'(send_val), 64'd0);
    check("bp.release.recv_rdy", 64'(recv_rdy), 64'd1);

    // Throughput: three frames with send_rdy high, one every 9 cycles.
    prev = 0;
    for (int f = 0; f < 3; f++) begin
      send_frame(1'b0, 40 + f * NS);
      check_frame($sformatf("tput%0d", f), 40 + f * NS);
      if (f > 0) check($sformatf("tput%0d.period", f), 64'(frame_cycle - prev), 64'd9);
      prev = frame_cycle;
    end
    recv_val = 1'b0;
    @(negedge clk);
    check("tput.end.send_val", 64'(send_val), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
